accum_seq: RTL

ACCUM_SEQ -- requirements
Module: accum_seq

---
 rtl/accum_pkg.sv | 12 +
 rtl/ripple_adder.sv | 23 ++
 rtl/accum_seq.sv | 121 ++++++++++++
 3 files changed

// File: rtl/accum_pkg.sv
// Shared definitions for the accumulate-and-emit sequencer: FSM encoding and count width.
package accum_pkg;

  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/ripple_adder.sv
// N-bit ripple-carry adder built from a chain of full-adder cells.
module ripple_adder #(
  parameter int unsigned N = 4
) (
  output logic         co,
  output logic [N-1:0] sum,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] a1,
  input  logic         ci
);

  logic [N:0] carry;

  assign carry[0] = ci;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]     = a0[i] ^ a1[i] ^ carry[i];
    assign carry[i+1] = (a0[i] & a1[i]) | (carry[i] & (a0[i] ^ a1[i]));
  end

  assign co = carry[N];

endmodule

// File: rtl/accum_seq.sv
// Accumulates LEN samples into one N-bit result with a carry-out flag, then holds it for handoff.
// Define ACC_SATURATE_EN to clamp the result to all-ones on carry instead of wrapping.
module accum_seq
  import accum_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned LEN = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_data,
  input  logic            clr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    acc,
  output logic            ovf,
  output logic [CntW-1:0] count
);

  localparam logic [CntW-1:0] LenC = CntW'(LEN);

  state_e          state_q, state_d;
  logic [N-1:0]    acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            live_q, live_d;

  logic            xfer;
  logic            add_co;
  logic [N-1:0]    add_sum;
  logic [N-1:0]    add_res;

  ripple_adder #(
    .N (N)
  ) u_adder (
    .co  (add_co),
    .sum (add_sum),
    .a0  (acc_q),
    .a1  (in_data),
    .ci  (1'b0)
  );

`ifdef ACC_SATURATE_EN
  // Once clamped, any further non-zero sample carries again, so the result stays all-ones.
  assign add_res = add_co ? {N{1'b1}} : add_sum;
`else
  assign add_res = add_sum;
`endif

  assign xfer   = in_valid & in_ready & ~clr;
  assign live_d = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (xfer) state_d = (LEN == 1) ? StDone : StAccum;
        StAccum: if (xfer && (cnt_q + CntW'(1)) == LenC) state_d = StDone;
        StDone:  if (out_ready) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // live_q keeps in_ready low until the first edge with rst_n released.
  always_comb begin
    in_ready  = live_q & (state_q != StDone);
    out_valid = (state_q == StDone);
    acc       = acc_q;
    ovf       = ovf_q;
    count     = cnt_q;
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (xfer) begin
      if (state_q == StIdle) begin
        acc_d = in_data;
        cnt_d = CntW'(1);
        ovf_d = 1'b0;
      end else begin
        acc_d = add_res;
        cnt_d = cnt_q + CntW'(1);
        ovf_d = ovf_q | add_co;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      live_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      live_q <= live_d;
    end
  end

endmodule
